// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor: one BLOCK-bit slice resolved per stage, valid/ready on both sides.
// Optional feature macro: CSEL_SUB_EN (honour the sub input; otherwise sub is ignored).
module csel_adder_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned N = WIDTH / BLOCK;

  // Stage k register feeds the slice computation of stage k.
  logic             v  [N];
  logic [WIDTH-1:0] ra [N];
  logic [WIDTH-1:0] rb [N];
  logic [WIDTH-1:0] rs [N];
  logic             rc [N];

  // Combinational result of each stage, captured by the next register.
  logic [WIDTH-1:0] nx_rs [N];
  logic             nx_c  [N];
  logic             nx_m  [N];

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_first;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

`ifdef CSEL_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign c_first = sub | cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign c_first    = cin;
`endif

  // Per-slice dual ripple (carry-in 0 and 1), selected by the carry registered from the previous stage.
  always_comb begin
    logic [BLOCK-1:0] sa, sb, s0, s1;
    logic             c0r, c1r, m0, m1;
    sa  = '0;
    sb  = '0;
    s0  = '0;
    s1  = '0;
    c0r = 1'b0;
    c1r = 1'b1;
    m0  = 1'b0;
    m1  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      nx_rs[k] = rs[k];
      nx_c[k]  = 1'b0;
      nx_m[k]  = 1'b0;
    end
    for (int unsigned k = 0; k < N; k++) begin
      sa  = ra[k][k*BLOCK +: BLOCK];
      sb  = rb[k][k*BLOCK +: BLOCK];
      c0r = 1'b0;
      c1r = 1'b1;
      for (int unsigned i = 0; i < BLOCK; i++) begin
        if (i == BLOCK - 1) begin
          m0 = c0r;
          m1 = c1r;
        end
        s0[i] = sa[i] ^ sb[i] ^ c0r;
        s1[i] = sa[i] ^ sb[i] ^ c1r;
        c0r   = (sa[i] & sb[i]) | (c0r & (sa[i] ^ sb[i]));
        c1r   = (sa[i] & sb[i]) | (c1r & (sa[i] ^ sb[i]));
      end
      nx_rs[k][k*BLOCK +: BLOCK] = rc[k] ? s1 : s0;
      nx_c[k] = rc[k] ? c1r : c0r;
      nx_m[k] = rc[k] ? m1 : m0;
    end
  end

  // Whole pipe moves together on advance; bubbles keep their slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) begin
        v[k]  <= 1'b0;
        ra[k] <= '0;
        rb[k] <= '0;
        rs[k] <= '0;
        rc[k] <= 1'b0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      v[0]  <= in_valid;
      ra[0] <= a;
      rb[0] <= b_eff;
      rs[0] <= '0;
      rc[0] <= c_first;
      for (int unsigned k = 1; k < N; k++) begin
        v[k]  <= v[k-1];
        ra[k] <= ra[k-1];
        rb[k] <= rb[k-1];
        rs[k] <= nx_rs[k-1];
        rc[k] <= nx_c[k-1];
      end
      out_valid <= v[N-1];
      sum       <= nx_rs[N-1];
      co        <= nx_c[N-1];
      ovf       <= nx_m[N-1] ^ nx_c[N-1];
    end
  end

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Scoreboard bench for csel_adder_pipe (WIDTH=16, BLOCK=4); follows CSEL_SUB_EN when defined.
module tb_csel_adder_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned BLOCK = 4;
  localparam int unsigned NST   = WIDTH / BLOCK;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  csel_adder_pipe #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .co(co), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] sb_q [$];
  int n_chk = 0;
  int n_pass = 0;
  int ncyc = 0;
  int pops = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  int vis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: {co, ovf, sum}
  function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic ci, input logic sb);
    logic        en;
    logic [15:0] be;
    logic        c0;
    logic [16:0] s;
    logic        cm;
`ifdef CSEL_SUB_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    be = (en && sb) ? ~bv : bv;
    c0 = (en && sb) ? 1'b1 : ci;
    s  = {1'b0, av} + {1'b0, be} + 17'(c0);
    cm = av[15] ^ be[15] ^ s[15];
    return {s[16], cm ^ s[16], s[15:0]};
  endfunction

  always @(negedge clk) begin : mon
    logic [17:0] e;
    ncyc++;
    if (rst_n && out_valid) begin
      vis++;
      if (out_ready) begin
        if (sb_q.size() == 0) check("unexpected_out", 32'(sb_q.size()), 32'd1);
        else begin
          e = sb_q.pop_front();
          check("result", 32'({co, ovf, sum}), 32'(e));
        end
        pops++;
        if (first_cyc < 0) first_cyc = ncyc;
        last_cyc = ncyc;
      end
    end
  end

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb);
    bit done = 0;
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(model(av, bv, ci, sb));
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_accept", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] hs;
    logic        hc, ho;
    int          lat;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_co", 32'(co), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Latency of a single operation
    send(16'h0006, 16'h0006, 1'b0, 1'b0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      lat = i;
      if (out_valid) break;
    end
    check("latency", 32'(lat), 32'(NST + 1));
    drain();

    // Carry-chain, overflow and subtract corners
    @(posedge clk); #1;
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0);
    send(16'h0000, 16'h0001, 1'b0, 1'b1);
    drain();

    // Back-to-back stream
    @(posedge clk); #1;
    pops = 0; first_cyc = -1; last_cyc = -1;
    for (int i = 0; i < 8; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    drain();
    check("b2b_count", 32'(pops), 32'd8);
    check("b2b_span", 32'(last_cyc - first_cyc), 32'd7);

    // Stall with full pipe
    @(posedge clk); #1;
    pops = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    @(negedge clk);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    hs = sum; hc = co; ho = ovf;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", 32'({hc, ho, hs}), 32'({co, ovf, sum}));
    end
    check("stall_ready_end", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'h1234, 16'h4321, 1'b1, 1'b0);
    drain();
    check("stall_count", 32'(pops), 32'd6);

    // Asynchronous reset with operations in flight
    @(posedge clk); #1;
    send(16'h8001, 16'h8001, 1'b0, 1'b0);
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h4444, 16'h5555, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_sum", 32'(sum), 32'd0);
    check("async_co", 32'(co), 32'd0);
    check("async_ovf", 32'(ovf), 32'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    vis = 0;
    repeat (10) @(negedge clk);
    check("no_ghost", 32'(vis), 32'd0);

    // Sanity after reset release
    @(posedge clk); #1;
    pops = 0;
    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    drain();
    check("post_rst_count", 32'(pops), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/csel_adder_pipe.md
# csel_adder_pipe

Parametrised, pipelined carry-select adder/subtractor: the successor of the fixed 4-bit carry-select adder. Operands of WIDTH bits are split into BLOCK-bit slices, one slice resolved per pipeline stage, with carry select inside each slice and a registered carry between stages. A valid/ready handshake on both sides lets it sit between streaming datapath blocks at full throughput of one operation per clock.

## Interface
- WIDTH, 16: operand/sum width; must be a multiple of BLOCK, WIDTH ≥ BLOCK.
- BLOCK, 4: slice width; number of stages N = WIDTH/BLOCK.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; **one clock; reset is asynchronous and active-low.**
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry in (add mode only).
- sub  input  1  1 = compute a − b (see Configuration).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- co  output  1  carry out of MSB (borrow-not in subtract).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Effective operands: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (k = 0..N−1) owns bits [k·BLOCK +: BLOCK]. It computes two ripple sums of that slice (carry-in 0 and carry-in 1) and selects with the registered carry from stage k−1 (stage 0 uses c0). Selected slice, next carry and the already-resolved lower bits move to the next register.
- Unresolved upper slices of a and b_eff travel alongside in skew registers; resolved bits never recomputed.
- Stage N−1 also registers co and ovf (needs carry into MSB, taken inside the last slice).
- Each stage register holds a valid bit; bubbles occupy a stage (no collapse).
- Arithmetic modulo 2^WIDTH; no saturation.

## Timing
- Reset (async assert, sync-safe release): all stage valids 0, out_valid 0, sum 0, co 0, ovf 0; in_ready = 1 once rst_n high.
- advance = !out_valid || out_ready; in_ready = advance (combinational from out_ready and out_valid).
- Accept: in_valid && in_ready at a rising edge.
- Latency N cycles: operand accepted at edge t gives out_valid = 1 after edge t+N−1+1, i.e. visible during cycle t+N, when no stall.
- Throughput: one operation per cycle while advance stays 1.
- Stall (out_valid && !out_ready): every stage, including outputs, holds; sum/co/ovf stable until taken.
- Accept and retire on the same edge allowed; order preserved strictly FIFO.
- in_valid with in_ready = 0: no capture; the producer must hold the request.
- rst_n assertion mid-stream discards all in-flight operations immediately (outputs clear asynchronously).
- N = 1 (WIDTH = BLOCK): single-cycle registered carry-select adder, same handshake.

## Configuration
- CSEL_SUB_EN defined: sub honoured as above.
- CSEL_SUB_EN undefined: sub ignored (treated as 0); b_eff = b, c0 = cin; no inversion logic built. Port remains for pin compatibility.

## Test plan
- WIDTH=16, BLOCK=4, out_ready=1: a=0x0006, b=0x0006, cin=0 -> 4 cycles later sum=0x000C, co=0, ovf=0.
- Full carry chain: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, co=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1.
- Subtract (CSEL_SUB_EN): a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, co=0; without macro same stimulus -> sum=0x000C.
- Back-to-back 8 random pairs, in_valid held 1 -> 8 consecutive out_valid cycles, results match reference model in order.
- Hold out_ready=0 for 5 cycles with pipe full -> in_ready=0, sum/co/ovf unchanged, no loss or duplicate after release.
- Assert rst_n low with 3 operations in flight -> out_valid, sum, co, ovf go 0 without a clock edge; none of those results emerge after release.
